hyperram_arb: RTL and testbench

Two-port round-robin arbiter that shares the single HyperRAM controller between the CPU-side memory port (port 0) and the video/streaming port (port 1). It sits between the requesters and the controller's go/busy command bus. It converts each requester's level-held request into a correctly timed go pulse, waits for completion, then returns a one-cycle acknowledge with captured read data. It also guards against a stalled controller with a watchdog.

---
 rtl/hyperram_arb_if.sv | 45 ++++
 rtl/hyperram_arb.sv | 165 ++++++++++++++++
 tb/tb_hyperram_arb.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hyperram_arb_if.sv
`timescale 1ns/1ps
// Requester and controller bus of the HyperRAM arbiter.
interface hyperram_arb_if;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;

  // requester side
  logic [1:0]    req_i;
  logic [CW-1:0] cmd0_i;
  logic [CW-1:0] cmd1_i;
  logic [AW-1:0] addr0_i;
  logic [AW-1:0] addr1_i;
  logic [DW-1:0] wdata0_i;
  logic [DW-1:0] wdata1_i;
  logic [1:0]    ack_o;
  logic [DW-1:0] rdata_o;
  logic          rvalid_o;
  logic          timeout_o;
  logic          grant_o;

  // controller side
  logic          mem_ready_i;
  logic          mem_busy_i;
  logic          mem_dvalid_i;
  logic [DW-1:0] mem_d_i;
  logic [AW-1:0] mem_a_o;
  logic [DW-1:0] mem_d_o;
  logic [CW-1:0] mem_cmd_o;
  logic          mem_go_o;

  modport slave (
    input  req_i, cmd0_i, cmd1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    input  mem_ready_i, mem_busy_i, mem_dvalid_i, mem_d_i,
    output ack_o, rdata_o, rvalid_o, timeout_o, grant_o,
    output mem_a_o, mem_d_o, mem_cmd_o, mem_go_o
  );

  modport master (
    output req_i, cmd0_i, cmd1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    output mem_ready_i, mem_busy_i, mem_dvalid_i, mem_d_i,
    input  ack_o, rdata_o, rvalid_o, timeout_o, grant_o,
    input  mem_a_o, mem_d_o, mem_cmd_o, mem_go_o
  );
endinterface

// File: rtl/hyperram_arb.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one HyperRAM controller between two ports,
// with go-pulse shaping, completion capture and a busy watchdog.
module hyperram_arb #(
  parameter int unsigned GO_HOLD = 4,
  parameter int unsigned GO_GAP  = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hyperram_arb_if.slave bus
);
  localparam int unsigned AW    = 24;
  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 3;
  localparam int unsigned CNT_W = 10;

  typedef enum logic [2:0] {
    S_WAIT_READY = 3'd0,
    S_IDLE       = 3'd1,
    S_ISSUE      = 3'd2,
    S_BUSY       = 3'd3,
    S_GAP        = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            grant_q, grant_d;
  logic            go_q, go_d;
  logic [1:0]      ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cmd_q, cmd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic start_c, win_c, issue_done_c, done_c, wd_exp_c, gap_done_c, is_read_c;

  // Shared decode: winner selection and phase-end conditions.
  always_comb begin
    start_c      = bus.mem_ready_i && (bus.req_i != 2'b00);
    win_c        = (bus.req_i == 2'b11) ? ~last_q : bus.req_i[1];
    issue_done_c = (cnt_q == CNT_W'(GO_HOLD - 1));
    done_c       = !bus.mem_busy_i;
    wd_exp_c     = (cnt_q == CNT_W'(TIMEOUT));
    gap_done_c   = (cnt_q == CNT_W'(GO_GAP - 1));
    is_read_c    = (cmd_q == 3'b010) || (cmd_q == 3'b011) || (cmd_q == 3'b111);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_WAIT_READY;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      go_q      <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      timeout_q <= 1'b0;
      cmd_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      go_q      <= go_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      timeout_q <= timeout_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT_READY: if (bus.mem_ready_i) state_d = S_IDLE;
      S_IDLE: begin
        if (!bus.mem_ready_i) state_d = S_WAIT_READY;
        else if (start_c)     state_d = S_ISSUE;
      end
      S_ISSUE: if (issue_done_c) state_d = S_BUSY;
      S_BUSY: begin
        if (done_c)        state_d = S_GAP;
        else if (wd_exp_c) state_d = S_WAIT_READY;
      end
      S_GAP: begin
        if (!bus.mem_ready_i) state_d = S_WAIT_READY;
        else if (gap_done_c)  state_d = S_IDLE;
      end
      default: state_d = S_WAIT_READY;
    endcase
  end

  // Next values of counter, command bus and completion outputs.
  always_comb begin
    cnt_d     = cnt_q;
    last_d    = last_q;
    grant_d   = grant_q;
    go_d      = 1'b0;
    ack_d     = 2'b00;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    timeout_d = 1'b0;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_c) begin
          grant_d = win_c;
          cmd_d   = win_c ? bus.cmd1_i   : bus.cmd0_i;
          addr_d  = win_c ? bus.addr1_i  : bus.addr0_i;
          wdata_d = win_c ? bus.wdata1_i : bus.wdata0_i;
          go_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        go_d  = !issue_done_c;
        cnt_d = issue_done_c ? '0 : cnt_q + CNT_W'(1);
      end
      S_BUSY: begin
        if (done_c) begin
          ack_d  = grant_q ? 2'b10 : 2'b01;
          last_d = grant_q;
          cnt_d  = '0;
          if (is_read_c) begin
            rdata_d  = bus.mem_d_i;
            rvalid_d = bus.mem_dvalid_i;
          end
        end else if (wd_exp_c) begin
          ack_d     = grant_q ? 2'b10 : 2'b01;
          timeout_d = 1'b1;
          last_d    = grant_q;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: cnt_d = gap_done_c ? '0 : cnt_q + CNT_W'(1);
      default: ;
    endcase
  end

  assign bus.ack_o     = ack_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.rvalid_o  = rvalid_q;
  assign bus.timeout_o = timeout_q;
  assign bus.grant_o   = grant_q;
  assign bus.mem_a_o   = addr_q;
  assign bus.mem_d_o   = wdata_q;
  assign bus.mem_cmd_o = cmd_q;
  assign bus.mem_go_o  = go_q;
endmodule

// File: tb/tb_hyperram_arb.sv
`timescale 1ns/1ps
// Directed bench for hyperram_arb: vector table plus corner-case sequences.
module tb_hyperram_arb;
  localparam int unsigned GO_HOLD = 4;
  localparam int unsigned GO_GAP  = 2;
  localparam int unsigned TIMEOUT = 1023;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  hyperram_arb_if bus ();

  hyperram_arb #(.GO_HOLD(GO_HOLD), .GO_GAP(GO_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [2:0]  cmd0;
    logic [23:0] addr0;
    logic [15:0] wdata0;
    logic [2:0]  cmd1;
    logic [23:0] addr1;
    logic [15:0] wdata1;
    int          busy;
    logic        dval;
    logic [15:0] md;
    logic        drop;
    logic        egrant;
    logic [1:0]  eack;
    logic [15:0] erdata;
    logic        erval;
  } vec_t;

  vec_t vecs[6];
  vec_t vrdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one transaction, play the controller, check bus, timing and ack.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int hold;
    logic [2:0]  ecmd;
    logic [23:0] eaddr;
    logic [15:0] ewd;
    ecmd  = v.egrant ? v.cmd1 : v.cmd0;
    eaddr = v.egrant ? v.addr1 : v.addr0;
    ewd   = v.egrant ? v.wdata1 : v.wdata0;
    bus.req_i = v.req;
    bus.cmd0_i = v.cmd0; bus.addr0_i = v.addr0; bus.wdata0_i = v.wdata0;
    bus.cmd1_i = v.cmd1; bus.addr1_i = v.addr1; bus.wdata1_i = v.wdata1;
    bus.mem_busy_i = 1'b0;
    bus.mem_d_i = v.md;
    bus.mem_dvalid_i = v.dval;
    n = 0;
    while (!bus.mem_go_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_go_seen", idx), bus.mem_go_o, 1);
    check($sformatf("v%0d_grant", idx), bus.grant_o, v.egrant);
    check($sformatf("v%0d_cmd", idx), bus.mem_cmd_o, ecmd);
    check($sformatf("v%0d_addr", idx), bus.mem_a_o, eaddr);
    check($sformatf("v%0d_wdata", idx), bus.mem_d_o, ewd);
    bus.mem_busy_i = (v.busy > 0);
    if (v.drop) bus.req_i = 2'b00;
    hold = 0;
    while (bus.mem_go_o && hold < 50) begin
      @(negedge clk);
      hold++;
    end
    check($sformatf("v%0d_go_hold", idx), hold, GO_HOLD);
    n = 0;
    while (n < 5000) begin
      if (n >= v.busy) bus.mem_busy_i = 1'b0;
      @(negedge clk);
      n++;
      if (bus.ack_o != 2'b00) break;
    end
    check($sformatf("v%0d_ack_lat", idx), n, v.busy + 1);
    check($sformatf("v%0d_ack", idx), bus.ack_o, v.eack);
    check($sformatf("v%0d_rdata", idx), bus.rdata_o, v.erdata);
    check($sformatf("v%0d_rvalid", idx), bus.rvalid_o, v.erval);
    check($sformatf("v%0d_timeout", idx), bus.timeout_o, 0);
    bus.req_i = 2'b00;
    @(negedge clk);
    check($sformatf("v%0d_ack_pulse", idx), bus.ack_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int   n;
    int   got;
    int   low_run;
    int   min_low;
    int   go_cnt;
    logic seen_go;
    logic exp_g;

    errors = 0;
    checks = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.req_i = '0;
    bus.cmd0_i = '0; bus.addr0_i = '0; bus.wdata0_i = '0;
    bus.cmd1_i = '0; bus.addr1_i = '0; bus.wdata1_i = '0;
    bus.mem_ready_i = 1'b0;
    bus.mem_busy_i = 1'b0;
    bus.mem_dvalid_i = 1'b0;
    bus.mem_d_i = '0;

    //         req    cmd0    addr0        wdata0    cmd1    addr1        wdata1    busy dval md        drop g     ack    rdata     rval
    vecs[0] = '{2'b11, 3'b000, 24'h000123, 16'hBEEF, 3'b010, 24'h000456, 16'h1111, 30, 1'b1, 16'hDEAD, 1'b0, 1'b0, 2'b01, 16'h0000, 1'b0};
    vecs[1] = '{2'b10, 3'b000, 24'h000000, 16'h0000, 3'b010, 24'h000456, 16'h1111, 5,  1'b1, 16'h5A5A, 1'b0, 1'b1, 2'b10, 16'h5A5A, 1'b1};
    vecs[2] = '{2'b01, 3'b011, 24'h000789, 16'h0000, 3'b000, 24'h000000, 16'h0000, 0,  1'b1, 16'h1234, 1'b0, 1'b0, 2'b01, 16'h1234, 1'b1};
    vecs[3] = '{2'b10, 3'b000, 24'h000000, 16'h0000, 3'b111, 24'hABCDEF, 16'h0000, 2,  1'b0, 16'h7777, 1'b0, 1'b1, 2'b10, 16'h7777, 1'b0};
    vecs[4] = '{2'b10, 3'b000, 24'h000000, 16'h0000, 3'b001, 24'h000100, 16'hCAFE, 3,  1'b1, 16'h9999, 1'b1, 1'b1, 2'b10, 16'h7777, 1'b0};
    vecs[5] = '{2'b11, 3'b100, 24'h000010, 16'h0042, 3'b010, 24'h000020, 16'h0000, 0,  1'b1, 16'h4444, 1'b0, 1'b0, 2'b01, 16'h7777, 1'b0};
    vrdy    = '{2'b10, 3'b000, 24'h000000, 16'h0000, 3'b001, 24'h000222, 16'h0F0F, 1,  1'b0, 16'h0000, 1'b0, 1'b1, 2'b10, 16'h7777, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_go", bus.mem_go_o, 0);
    check("rst_ack", bus.ack_o, 0);
    check("rst_grant", bus.grant_o, 0);
    check("rst_addr", bus.mem_a_o, 0);
    check("rst_wdata", bus.mem_d_o, 0);
    check("rst_cmd", bus.mem_cmd_o, 0);
    check("rst_rdata", bus.rdata_o, 0);
    check("rst_rvalid", bus.rvalid_o, 0);
    check("rst_timeout", bus.timeout_o, 0);
    rst = 1'b0;

    // controller not ready: requests must be ignored
    bus.req_i = 2'b11;
    go_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_go_o) go_cnt++;
    end
    check("unready_no_go", go_cnt, 0);
    bus.mem_ready_i = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // both ports request continuously: grants alternate, first to port 1
    bus.req_i = 2'b11;
    bus.cmd0_i = 3'b000; bus.cmd1_i = 3'b001;
    bus.mem_busy_i = 1'b0;
    bus.mem_dvalid_i = 1'b0;
    exp_g = 1'b1;
    got = 0; n = 0; low_run = 0; min_low = 1000; seen_go = 1'b0;
    while (got < 6 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.mem_go_o) begin
        if (seen_go && low_run > 0 && low_run < min_low) min_low = low_run;
        low_run = 0;
        seen_go = 1'b1;
      end else begin
        low_run++;
      end
      if (bus.ack_o != 2'b00) begin
        check($sformatf("alt%0d_grant", got), bus.grant_o, exp_g);
        check($sformatf("alt%0d_ack", got), bus.ack_o, exp_g ? 2'b10 : 2'b01);
        exp_g = ~exp_g;
        got++;
      end
    end
    bus.req_i = 2'b00;
    check("alt_count", got, 6);
    check("alt_go_low", min_low, GO_GAP + 2);
    repeat (4) @(negedge clk);

    // ready drops in IDLE: pending request held, served once ready returns
    bus.mem_ready_i = 1'b0;
    bus.req_i = 2'b10;
    go_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_go_o) go_cnt++;
    end
    check("ready_drop_no_go", go_cnt, 0);
    check("ready_drop_no_ack", bus.ack_o, 0);
    bus.mem_ready_i = 1'b1;
    run_vec(vrdy, 6);

    // stuck busy: watchdog abort after TIMEOUT+1 busy cycles
    bus.req_i = 2'b01;
    bus.cmd0_i = 3'b010; bus.addr0_i = 24'h000333; bus.wdata0_i = 16'h0000;
    bus.mem_busy_i = 1'b1;
    bus.mem_dvalid_i = 1'b1;
    bus.mem_d_i = 16'h1111;
    n = 0;
    while (!bus.mem_go_o && n < 50) begin @(negedge clk); n++; end
    check("to_go_seen", bus.mem_go_o, 1);
    n = 0;
    while (bus.mem_go_o && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (n < 1100) begin
      @(negedge clk);
      n++;
      if (bus.ack_o != 2'b00) break;
    end
    check("to_lat", n, TIMEOUT + 1);
    check("to_pulse", bus.timeout_o, 1);
    check("to_ack", bus.ack_o, 2'b01);
    check("to_rvalid", bus.rvalid_o, 0);
    bus.mem_busy_i = 1'b0;
    @(negedge clk);
    check("to_pulse_end", bus.timeout_o, 0);
    check("to_wait_ready_go", bus.mem_go_o, 0);
    @(negedge clk);
    check("to_reissue_go", bus.mem_go_o, 1);
    n = 0;
    while (bus.ack_o == 2'b00 && n < 30) begin @(negedge clk); n++; end
    check("to_retry_ack", bus.ack_o, 2'b01);
    check("to_retry_rdata", bus.rdata_o, 16'h1111);
    check("to_retry_rvalid", bus.rvalid_o, 1);
    bus.req_i = 2'b00;
    repeat (4) @(negedge clk);

    // reset in the middle of a command: no ack, outputs cleared
    bus.req_i = 2'b10;
    bus.cmd1_i = 3'b010; bus.addr1_i = 24'h000444;
    n = 0;
    while (!bus.mem_go_o && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_go", bus.mem_go_o, 0);
    check("mid_rst_grant", bus.grant_o, 0);
    check("mid_rst_cmd", bus.mem_cmd_o, 0);
    check("mid_rst_rdata", bus.rdata_o, 0);
    rst = 1'b0;
    bus.req_i = 2'b00;
    go_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack_o != 2'b00) go_cnt++;
    end
    check("mid_rst_no_ack", go_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
